// File: rtl/rdma_rd_resp_framer.sv
// RDMA read-response framer: takes one read request, then frames the raw user payload
// stream into a single tid-tagged AXI4-Stream packet and reports completion.
module rdma_rd_resp_framer #(
    parameter int DATA_BITS = 512,
    parameter int REQ_BITS  = 96,
    parameter int LEN_BITS  = 28,
    parameter int ID_BITS   = 6
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_req_valid,
    output logic                   s_req_ready,
    input  logic [REQ_BITS-1:0]    s_req_data,
    input  logic                   s_axis_src_tvalid,
    output logic                   s_axis_src_tready,
    input  logic [DATA_BITS-1:0]   s_axis_src_tdata,
    output logic                   m_axis_rd_tvalid,
    input  logic                   m_axis_rd_tready,
    output logic [DATA_BITS-1:0]   m_axis_rd_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_rd_tkeep,
    output logic [ID_BITS-1:0]     m_axis_rd_tid,
    output logic                   m_axis_rd_tlast,
    output logic                   m_done_valid,
    input  logic                   m_done_ready,
    output logic [ID_BITS-1:0]     m_done_id,
    output logic                   err_zero_len
);

    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int          LO_BITS    = $clog2(BEAT_BYTES);
    localparam int          CNT_BITS   = LEN_BITS - LO_BITS + 1;
    localparam int          ID_LSB     = 48 + LEN_BITS;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                  state, state_nxt;
    logic [ID_BITS-1:0]      id_q;
    logic [CNT_BITS-1:0]     remain_q;
    logic [LO_BITS-1:0]      tail_q;
    logic                    err_q;

    logic [LEN_BITS-1:0]     req_len;
    logic [ID_BITS-1:0]      req_id;
    logic [CNT_BITS-1:0]     req_beats;
    logic                    req_fire, rd_fire, last_beat;
    logic [BEAT_BYTES-1:0]   last_keep;
    logic                    unused_req_bits;

    assign req_len   = s_req_data[48 +: LEN_BITS];
    assign req_id    = s_req_data[ID_LSB +: ID_BITS];
    assign req_beats = CNT_BITS'(req_len >> LO_BITS)
                     + CNT_BITS'(req_len[LO_BITS-1:0] != '0);
    assign unused_req_bits = ^{s_req_data[47:0], s_req_data[REQ_BITS-1:ID_LSB+ID_BITS]};

    // Handshakes derived from state and inputs only, so the output process has no loop.
    assign req_fire  = (state == IDLE) && s_req_valid && !areset;
    assign rd_fire   = (state == STREAM) && s_axis_src_tvalid && m_axis_rd_tready && !areset;
    assign last_beat = (remain_q == CNT_BITS'(1));

    always_comb begin
        last_keep = '0;
        for (int unsigned i = 0; i < BEAT_BYTES; i++)
            last_keep[i] = (tail_q == '0) || (i < 32'(tail_q));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            id_q     <= '0;
            remain_q <= '0;
            tail_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= req_fire && (req_len == '0);
            if (req_fire && (req_len != '0)) begin
                id_q     <= req_id;
                remain_q <= req_beats;
                tail_q   <= req_len[LO_BITS-1:0];
            end else if (rd_fire) begin
                remain_q <= remain_q - CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        s_req_ready       = 1'b0;
        s_axis_src_tready = 1'b0;
        m_axis_rd_tvalid  = 1'b0;
        m_axis_rd_tdata   = '0;
        m_axis_rd_tkeep   = '0;
        m_axis_rd_tid     = '0;
        m_axis_rd_tlast   = 1'b0;
        m_done_valid      = 1'b0;
        m_done_id         = '0;
        case (state)
            IDLE: begin
                s_req_ready = !areset;
                if (req_fire && (req_len != '0))
                    state_nxt = STREAM;
            end
            STREAM: begin
                m_axis_rd_tvalid  = s_axis_src_tvalid && !areset;
                s_axis_src_tready = m_axis_rd_tready && !areset;
                m_axis_rd_tdata   = s_axis_src_tdata;
                m_axis_rd_tid     = id_q;
                m_axis_rd_tlast   = last_beat;
                m_axis_rd_tkeep   = last_beat ? last_keep : '1;
                if (rd_fire && last_beat)
                    state_nxt = DONE;
            end
            DONE: begin
                m_done_valid = !areset;
                m_done_id    = id_q;
                if (m_done_ready && !areset)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign err_zero_len = err_q;

endmodule
